// File: rtl/bpu_pkg.sv
// Shared types and default geometry for the branch prediction table write path.
package bpu_pkg;

  localparam int unsigned BPU_XLEN      = 32;
  localparam int unsigned BPU_ENTRY_NUM = 64;
  localparam int unsigned BPU_UPD_DEPTH = 4;
  localparam int unsigned TBL_W         = $clog2(BPU_ENTRY_NUM);

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_ALLOC  = 2'b01,
    OP_UPDATE = 2'b10,
    OP_INVAL  = 2'b11
  } tbl_op_e;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [TBL_W-1:0]    idx;
    logic                taken;
    logic [BPU_XLEN-1:0] target;
  } upd_entry_t;

endpackage

// File: rtl/bpu_upd_fifo.sv
// Resolution-update FIFO; head is visible combinationally, clear empties it in one cycle.
module bpu_upd_fifo import bpu_pkg::*; #(
  parameter int unsigned DEPTH = BPU_UPD_DEPTH
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       push_i,
  input  upd_entry_t din_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output upd_entry_t head_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  upd_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (r_cnt == DEPTH[PW:0]);
  assign empty_o = (r_cnt == '0);
  assign head_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (clear_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !clear_i) r_mem[r_wr_ptr] <= din_i;
  end

endmodule

// File: rtl/bpu_wr_sched.sv
// Arbitrates the single table write port between invalidation sweep, decode
// allocations and buffered execute updates; all table outputs are registered.
module bpu_wr_sched import bpu_pkg::*; #(
  parameter int unsigned XLEN      = BPU_XLEN,
  parameter int unsigned ENTRY_NUM = BPU_ENTRY_NUM,
  parameter int unsigned UPD_DEPTH = BPU_UPD_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         stall_i,
  input  logic                         alloc_req_i,
  input  logic [XLEN-1:0]              alloc_pc_i,
  input  logic                         alloc_taken_i,
  output logic                         alloc_ready_o,
  input  logic                         upd_valid_i,
  input  logic [$clog2(ENTRY_NUM)-1:0] upd_idx_i,
  input  logic                         upd_taken_i,
  input  logic [XLEN-1:0]              upd_target_i,
  output logic                         upd_ready_o,
  input  logic                         flush_req_i,
  output logic                         flush_busy_o,
  output logic                         predict_en_o,
  output logic                         tbl_we_o,
  output logic [1:0]                   tbl_op_o,
  output logic [$clog2(ENTRY_NUM)-1:0] tbl_idx_o,
  output logic [XLEN-1:0]              tbl_pc_o,
  output logic [XLEN-1:0]              tbl_target_o,
  output logic                         tbl_taken_o,
  output logic [15:0]                  drop_cnt_o
);

  localparam int unsigned IW = $clog2(ENTRY_NUM);

  sched_state_e  r_state, w_state_nx;
  logic [IW-1:0] r_sweep, w_sweep_nx;
  logic [IW-1:0] r_alloc_ptr, w_alloc_ptr_nx;
  logic [15:0]   r_drop_cnt;

  logic          w_full, w_empty, w_push, w_pop, w_clear, w_run;
  upd_entry_t    w_head, w_push_data;

  logic          w_we, r_we;
  tbl_op_e       w_op, r_op;
  logic [IW-1:0] w_idx, r_idx;
  logic [XLEN-1:0] w_pc, r_pc, w_target, r_target;
  logic          w_taken, r_taken;

  assign w_run         = (r_state == ST_RUN);
  assign upd_ready_o   = w_run & ~w_full;
  assign alloc_ready_o = w_run & ~stall_i & ~w_full & ~flush_req_i;
  assign flush_busy_o  = ~w_run;
  assign predict_en_o  = w_run;
  assign w_push        = upd_valid_i & upd_ready_o;
  assign w_push_data   = '{idx: upd_idx_i, taken: upd_taken_i, target: upd_target_i};

  bpu_upd_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (w_clear),
    .push_i  (w_push),
    .din_i   (w_push_data),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  always_comb begin
    w_state_nx     = r_state;
    w_sweep_nx     = r_sweep;
    w_alloc_ptr_nx = r_alloc_ptr;
    w_pop          = 1'b0;
    w_clear        = 1'b0;
    w_we           = 1'b0;
    w_op           = OP_NOP;
    w_idx          = '0;
    w_pc           = '0;
    w_target       = '0;
    w_taken        = 1'b0;
    if (!stall_i) begin
      if (flush_req_i) begin
        w_state_nx     = ST_FLUSH;
        w_sweep_nx     = '0;
        w_alloc_ptr_nx = '0;
        w_clear        = 1'b1;
      end else if (r_state == ST_FLUSH) begin
        w_we       = 1'b1;
        w_op       = OP_INVAL;
        w_idx      = r_sweep;
        w_sweep_nx = r_sweep + IW'(1);
        if (r_sweep == IW'(ENTRY_NUM - 1)) w_state_nx = ST_RUN;
      end else if (w_full) begin
        w_pop    = 1'b1;
        w_we     = 1'b1;
        w_op     = OP_UPDATE;
        w_idx    = w_head.idx;
        w_target = w_head.target;
        w_taken  = w_head.taken;
      end else if (alloc_req_i) begin
        w_we           = 1'b1;
        w_op           = OP_ALLOC;
        w_idx          = r_alloc_ptr;
        w_pc           = alloc_pc_i;
        w_taken        = alloc_taken_i;
        w_alloc_ptr_nx = r_alloc_ptr + IW'(1);
        // A queued update for the slot being reallocated belongs to the evicted branch.
        w_pop          = ~w_empty & (w_head.idx == r_alloc_ptr);
      end else if (!w_empty) begin
        w_pop    = 1'b1;
        w_we     = 1'b1;
        w_op     = OP_UPDATE;
        w_idx    = w_head.idx;
        w_target = w_head.target;
        w_taken  = w_head.taken;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_FLUSH;
      r_sweep     <= '0;
      r_alloc_ptr <= '0;
      r_drop_cnt  <= '0;
      r_we        <= 1'b0;
      r_op        <= OP_NOP;
      r_idx       <= '0;
      r_pc        <= '0;
      r_target    <= '0;
      r_taken     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_sweep     <= w_sweep_nx;
      r_alloc_ptr <= w_alloc_ptr_nx;
      r_we        <= w_we;
      r_op        <= w_op;
      r_idx       <= w_idx;
      r_pc        <= w_pc;
      r_target    <= w_target;
      r_taken     <= w_taken;
      if (upd_valid_i && !upd_ready_o && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign tbl_we_o     = r_we;
  assign tbl_op_o     = r_op;
  assign tbl_idx_o    = r_idx;
  assign tbl_pc_o     = r_pc;
  assign tbl_target_o = r_target;
  assign tbl_taken_o  = r_taken;
  assign drop_cnt_o   = r_drop_cnt;

endmodule

// File: tb/tb_bpu_wr_sched.sv
// Bench for bpu_wr_sched: queue-based reference model checked every cycle,
// plus literal expectations on the logged table writes.
module tb_bpu_wr_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall, alloc_req, alloc_taken, upd_valid, upd_taken, flush_req;
  logic [31:0] alloc_pc, upd_target;
  logic [5:0]  upd_idx;
  logic        alloc_ready, upd_ready, flush_busy, predict_en, tbl_we, tbl_taken;
  logic [1:0]  tbl_op;
  logic [5:0]  tbl_idx;
  logic [31:0] tbl_pc, tbl_target;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  bpu_wr_sched #(.XLEN(32), .ENTRY_NUM(64), .UPD_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
    .alloc_req_i(alloc_req), .alloc_pc_i(alloc_pc), .alloc_taken_i(alloc_taken),
    .alloc_ready_o(alloc_ready),
    .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_ready_o(upd_ready),
    .flush_req_i(flush_req), .flush_busy_o(flush_busy), .predict_en_o(predict_en),
    .tbl_we_o(tbl_we), .tbl_op_o(tbl_op), .tbl_idx_o(tbl_idx), .tbl_pc_o(tbl_pc),
    .tbl_target_o(tbl_target), .tbl_taken_o(tbl_taken), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int idx; bit tkn; logic [31:0] tgt; } upd_t;
  upd_t mq[$];
  bit   m_flush;
  int   m_sweep, m_ptr, m_drop;
  int   e_we, e_op, e_idx, e_tkn;
  logic [31:0] e_pc, e_tgt;

  task automatic model_reset();
    mq.delete();
    m_flush = 1; m_sweep = 0; m_ptr = 0; m_drop = 0;
    e_we = 0; e_op = 0; e_idx = 0; e_tkn = 0; e_pc = '0; e_tgt = '0;
  endtask

  task automatic issue_update();
    upd_t h;
    h = mq.pop_front();
    e_we = 1; e_op = 2; e_idx = h.idx; e_tgt = h.tgt; e_tkn = int'(h.tkn);
  endtask

  task automatic model_step();
    bit ready, flushed;
    ready   = !m_flush && mq.size() < 4;
    flushed = 0;
    e_we = 0; e_op = 0; e_idx = 0; e_tkn = 0; e_pc = '0; e_tgt = '0;
    if (!stall) begin
      if (flush_req) begin
        m_flush = 1; m_sweep = 0; m_ptr = 0; mq.delete(); flushed = 1;
      end else if (m_flush) begin
        e_we = 1; e_op = 3; e_idx = m_sweep;
        if (m_sweep == 63) m_flush = 0;
        m_sweep = (m_sweep + 1) % 64;
      end else if (mq.size() == 4) begin
        issue_update();
      end else if (alloc_req) begin
        e_we = 1; e_op = 1; e_idx = m_ptr; e_pc = alloc_pc; e_tkn = int'(alloc_taken);
        if (mq.size() > 0 && mq[0].idx == m_ptr) void'(mq.pop_front());
        m_ptr = (m_ptr + 1) % 64;
      end else if (mq.size() > 0) begin
        issue_update();
      end
    end
    if (upd_valid) begin
      if (!ready) begin
        if (m_drop < 65535) m_drop++;
      end else if (!flushed) begin
        mq.push_back('{idx: int'(upd_idx), tkn: upd_taken, tgt: upd_target});
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare + write log ----------------
  typedef struct { int op; int idx; logic [31:0] pc; logic [31:0] tgt; } wr_t;
  wr_t wlog[$];

  initial forever begin
    @(posedge clk);
    #1;
    if (chk_on) begin
      chk("tbl_we", tbl_we, e_we);
      chk("tbl_op", tbl_op, e_op);
      chk("tbl_idx", tbl_idx, e_idx);
      chk("tbl_pc", tbl_pc, e_pc);
      chk("tbl_target", tbl_target, e_tgt);
      chk("tbl_taken", tbl_taken, e_tkn);
      chk("flush_busy", flush_busy, m_flush);
      chk("predict_en", predict_en, !m_flush);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("upd_ready", upd_ready, !m_flush && mq.size() < 4);
      chk("alloc_ready", alloc_ready, !m_flush && mq.size() < 4 && !stall && !flush_req);
      if (tbl_we === 1'b1)
        wlog.push_back('{op: int'(tbl_op), idx: int'(tbl_idx), pc: tbl_pc, tgt: tbl_target});
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_log(string nm, int k, int op, int idx, logic [31:0] pc, logic [31:0] tgt);
    if (k >= wlog.size()) chk({nm, "_present"}, wlog.size(), k + 1);
    else begin
      chk({nm, "_op"}, wlog[k].op, op);
      chk({nm, "_idx"}, wlog[k].idx, idx);
      chk({nm, "_pc"}, wlog[k].pc, pc);
      chk({nm, "_tgt"}, wlog[k].tgt, tgt);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    stall = 0; alloc_req = 0; alloc_taken = 0; upd_valid = 0; upd_taken = 0;
    flush_req = 0; alloc_pc = '0; upd_target = '0; upd_idx = '0;
    #1 rst_n = 0;
    #1 chk_on = 1;
    tick(2);
    chk("rst_busy", flush_busy, 1);
    chk("rst_pred", predict_en, 0);
    chk("rst_we", tbl_we, 0);
    chk("rst_drop", drop_cnt, 0);

    // reset sweep
    rst_n = 1; wlog.delete();
    tick(64);
    chk("sweep_len", wlog.size(), 64);
    chk_log("sweep_first", 0, 3, 0, 0, 0);
    chk_log("sweep_last", 63, 3, 63, 0, 0);
    chk("sweep_busy", flush_busy, 0);
    chk("sweep_pred", predict_en, 1);
    tick(3);
    chk("idle_len", wlog.size(), 64);

    // three allocations
    wlog.delete();
    alloc_req = 1; alloc_pc = 32'h100; alloc_taken = 1; tick(1);
    alloc_pc = 32'h200; alloc_taken = 0; tick(1);
    alloc_pc = 32'h300; alloc_taken = 1; tick(1);
    alloc_req = 0; tick(2);
    chk("alloc3_len", wlog.size(), 3);
    chk_log("alloc_a", 0, 1, 0, 32'h100, 0);
    chk_log("alloc_b", 1, 1, 1, 32'h200, 0);
    chk_log("alloc_c", 2, 1, 2, 32'h300, 0);

    // 64-allocation run wraps the pointer
    wlog.delete(); alloc_req = 1;
    for (int i = 0; i < 64; i++) begin
      alloc_pc = 32'h1000 + 32'(i * 4); alloc_taken = 1'(i & 1); tick(1);
    end
    alloc_req = 0; tick(2);
    chk("wrap_len", wlog.size(), 64);
    chk_log("wrap_first", 0, 1, 3, 32'h1000, 0);
    chk_log("wrap_top", 60, 1, 63, 32'h10F0, 0);
    chk_log("wrap_zero", 61, 1, 0, 32'h10F4, 0);
    chk_log("wrap_last", 63, 1, 2, 32'h10FC, 0);

    // 5 pushes while stalled: one dropped, then drained in order
    wlog.delete(); stall = 1; upd_valid = 1;
    for (int i = 0; i < 5; i++) begin
      upd_idx = 6'(10 + i); upd_target = 32'hA000 + 32'(i); upd_taken = 1'(i & 1); tick(1);
    end
    upd_valid = 0;
    chk("stall_drop", drop_cnt, 1);
    chk("stall_rdy", upd_ready, 0);
    chk("stall_nowr", wlog.size(), 0);
    stall = 0; tick(6);
    chk("drain_len", wlog.size(), 4);
    for (int k = 0; k < 4; k++) chk_log("drain", k, 2, 10 + k, 0, 32'hA000 + 32'(k));

    // full FIFO blocks allocation until one update drains
    wlog.delete(); stall = 1; upd_valid = 1;
    for (int i = 0; i < 4; i++) begin
      upd_idx = 6'(20 + i); upd_target = 32'hB000 + 32'(i); tick(1);
    end
    upd_valid = 0; stall = 0; alloc_req = 1; alloc_pc = 32'h400; alloc_taken = 0;
    #1 chk("full_ardy", alloc_ready, 0);
    tick(1);
    chk("drain_ardy", alloc_ready, 1);
    tick(1); alloc_req = 0; tick(5);
    chk("fullarb_len", wlog.size(), 5);
    chk_log("fullarb_upd", 0, 2, 20, 0, 32'hB000);
    chk_log("fullarb_alloc", 1, 1, 3, 32'h400, 0);
    chk_log("fullarb_rest", 2, 2, 21, 0, 32'hB001);
    chk_log("fullarb_tail", 4, 2, 23, 0, 32'hB003);

    // stale-update hazard: head idx equals allocation pointer
    wlog.delete();
    alloc_req = 1; alloc_pc = 32'h500; tick(1); alloc_req = 0;
    stall = 1; upd_valid = 1; upd_idx = 6'd5; upd_target = 32'hC005; tick(1);
    upd_idx = 6'd7; upd_target = 32'hC007; tick(1);
    upd_valid = 0; stall = 0; alloc_req = 1; alloc_pc = 32'h600; tick(1);
    alloc_req = 0; tick(3);
    chk("stale_len", wlog.size(), 3);
    chk_log("stale_a4", 0, 1, 4, 32'h500, 0);
    chk_log("stale_a5", 1, 1, 5, 32'h600, 0);
    chk_log("stale_u7", 2, 2, 7, 0, 32'hC007);

    // flush from RUN with queued updates, restart mid-sweep at 30
    stall = 1; upd_valid = 1; upd_idx = 6'd9; upd_target = 32'hD009; tick(2);
    upd_valid = 0; stall = 0;
    wlog.delete(); flush_req = 1; alloc_req = 1; alloc_pc = 32'h700;
    #1 chk("flush_ardy", alloc_ready, 0);
    tick(1); flush_req = 0; alloc_req = 0;
    tick(29);
    upd_valid = 1; upd_idx = 6'd1; tick(1); upd_valid = 0;
    chk("flush_drop", drop_cnt, 2);
    flush_req = 1; tick(1); flush_req = 0;
    tick(66);
    chk("reflush_len", wlog.size(), 94);
    chk_log("reflush_29", 29, 3, 29, 0, 0);
    chk_log("reflush_0", 30, 3, 0, 0, 0);
    chk_log("reflush_63", 93, 3, 63, 0, 0);
    chk("reflush_pred", predict_en, 1);

    // asynchronous reset mid-sweep
    flush_req = 1; tick(1); flush_req = 0; tick(10);
    #2 rst_n = 0;
    #1;
    chk("arst_we", tbl_we, 0);
    chk("arst_idx", tbl_idx, 0);
    chk("arst_op", tbl_op, 0);
    chk("arst_busy", flush_busy, 1);
    chk("arst_pred", predict_en, 0);
    chk("arst_drop", drop_cnt, 0);
    tick(2); wlog.delete(); rst_n = 1;
    tick(66);
    chk("arst_len", wlog.size(), 64);
    chk_log("arst_first", 0, 3, 0, 0, 0);
    chk_log("arst_last", 63, 3, 63, 0, 0);

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bpu_wr_sched.md
Name: bpu_wr_sched

Overview:
- Write-port scheduler for the branch prediction table (PC tag, target, 2-bit counter per entry).
- The table has a single write port. This block shares it between three sources:
  - decode-stage allocations of newly seen branches;
  - execute-stage resolution updates, buffered in a small FIFO;
  - a full-table invalidation sweep, run at reset and on flush requests.
- Sits between Decode/Execute and the table; the table only executes the opcode presented on tbl_*.

Parameters:
XLEN, 32, address/PC width
ENTRY_NUM, 64, table entries (power of 2)
UPD_DEPTH, 4, resolution FIFO depth (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
stall_i  in  1  pipeline stall; freezes scheduling
alloc_req_i  in  1  decode requests a new entry
alloc_pc_i  in  XLEN  branch PC to allocate
alloc_taken_i  in  1  initial direction
alloc_ready_o  out  1  allocation accepted this cycle when high with alloc_req_i
upd_valid_i  in  1  execute resolved a branch that hit in the table
upd_idx_i  in  $clog2(ENTRY_NUM)  entry index of resolved branch
upd_taken_i  in  1  actual direction
upd_target_i  in  XLEN  actual target
upd_ready_o  out  1  FIFO not full
flush_req_i  in  1  invalidate whole table (fence.i / context switch)
flush_busy_o  out  1  sweep in progress
predict_en_o  out  1  table contents valid for prediction
tbl_we_o  out  1  table write strobe (registered)
tbl_op_o  out  2  ALLOC=01, UPDATE=10, INVAL=11
tbl_idx_o  out  $clog2(ENTRY_NUM)  entry index
tbl_pc_o  out  XLEN  tag for ALLOC, else 0
tbl_target_o  out  XLEN  target for ALLOC/UPDATE
tbl_taken_o  out  1  direction for ALLOC/UPDATE
drop_cnt_o  out  16  saturating count of updates lost to a full FIFO

Behaviour:
- FSM states:
  - FLUSH: entered on reset or flush_req_i. Issues INVAL for sweep_idx, then sweep_idx+1. At sweep_idx==ENTRY_NUM-1 it goes to RUN. Costs ENTRY_NUM non-stalled cycles.
  - RUN: normal arbitration.
- Reset values: state=FLUSH, sweep_idx=0, alloc_ptr=0, FIFO empty, drop_cnt_o=0. All tbl_* outputs 0; flush_busy_o=1; predict_en_o=0.
- Timing: tbl_* outputs are registered. A decision taken in cycle t drives tbl_we_o=1 during cycle t+1. It drives tbl_we_o=0 in every cycle where no decision was taken.
- FIFO:
  - Push when upd_valid_i & upd_ready_o; upd_ready_o = ~full & state==RUN.
  - upd_valid_i while full or FLUSH: entry dropped. drop_cnt_o increments, saturating at 16'hFFFF.
  - A push to an empty FIFO is not poppable in the same cycle (minimum accept-to-write latency is 2 cycles).
- RUN arbitration, one write per non-stalled cycle:
  - If the FIFO is full: UPDATE wins, alloc_ready_o=0.
  - Else, if alloc_req_i: ALLOC wins. tbl_idx=alloc_ptr; alloc_ptr advances, wrapping ENTRY_NUM-1 -> 0.
  - Else, if the FIFO is not empty: pop the head and issue UPDATE.
- Stale-update hazard: if ALLOC wins and the FIFO head idx == alloc_ptr, the head is popped without a write, in the same cycle. It refers to the evicted branch.
- alloc_ready_o = state==RUN & ~stall_i & ~full.
- stall_i=1:
  - no decision taken; FSM, alloc_ptr and sweep_idx hold;
  - FIFO pushes are still accepted and nothing is popped;
  - tbl_we_o=0 next cycle.
- flush_req_i:
  - From RUN: next state FLUSH, sweep_idx=0, FIFO cleared, alloc_ptr=0.
  - During FLUSH: the sweep restarts at 0.
  - Same cycle as a winning ALLOC: the flush takes priority and the ALLOC is not accepted (alloc_ready_o=0 while flush_req_i=1).
- predict_en_o = ~flush_busy_o = (state==RUN), registered.
- Asynchronous reset mid-sweep: restarts in FLUSH at 0.

Decomposition:
- Shared package bpu_pkg:
  - tbl_op_e (NOP/ALLOC/UPDATE/INVAL);
  - sched_state_e (FLUSH/RUN);
  - TBL_W = $clog2(ENTRY_NUM);
  - upd_entry_t struct {idx, taken, target}.
- One sub-module: bpu_upd_fifo.
  - Synchronous FIFO of upd_entry_t, UPD_DEPTH deep, with asynchronous active-low reset.
  - Exposes full, empty, head and clear.

Test Plan:
- Reset release, no stimulus -> INVAL idx 0..63 on cycles 1..64, flush_busy_o falls after the last one, predict_en_o=1, tbl_we_o=0 afterwards.
- Three allocs (PC 0x100, 0x200, 0x300) -> ALLOC at idx 0, 1, 2. Then a 64-alloc run -> wraps to idx 0 on the 65th.
- Push 5 updates with no allocs, stall_i=1, UPD_DEPTH=4 -> upd_ready_o=0 after 4 pushes, drop_cnt_o=1. Release stall -> 4 UPDATEs in push order.
- FIFO full (4 entries) plus continuous alloc_req_i -> alloc_ready_o=0 until one UPDATE drains, then the ALLOC is accepted.
- FIFO head idx=5, alloc_ptr=5, alloc_req_i -> ALLOC idx 5, head discarded, no UPDATE to idx 5.
- flush_req_i asserted at sweep_idx=30 -> sweep restarts at 0, total 64 more INVALs. Same test, deassert rst_ni mid-sweep -> outputs return to reset values immediately.
